// File: rtl/wb_avalon_master_bridge.sv
// Wishbone classic slave to Avalon-MM master bridge with timeout, error mapping and error counter.
// Latency: Avalon command 1 cycle after stb is sampled; ack/err 1 cycle after Avalon completion.
// Backpressure: command held under m_waitrequest; Wishbone master waits for ack/err.
module wb_avalon_master_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  input  logic                  m_waitrequest,
  input  logic [1:0]            m_response,
  output logic [7:0]            err_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_RDWAIT = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic [2:0]      state;
  logic            stale;     // a timed-out read still owes us one readdatavalid beat
  logic            abort_q;   // master dropped cyc during this transfer
  logic [TO_W-1:0] to_cnt;    // saturates at TO_LIM so a late accept cannot wrap it

  logic to_hit;
  logic quiet;
  logic rd_err;
  logic finish;
  logic fin_err;
  logic capture;
  logic to_stale;

  assign to_hit = (TIMEOUT != 0) && (to_cnt >= TO_LIM - 1'b1);
  assign quiet  = abort_q | ~wb_cyc_i;
  assign rd_err = (m_response != 2'b00);

  // Decide whether this cycle completes the transfer, with what status, and whether read data lands.
  always_comb begin
    finish   = 1'b0;
    fin_err  = 1'b0;
    capture  = 1'b0;
    to_stale = 1'b0;
    case (state)
      S_REQ: begin
        if (!m_waitrequest) begin
          if (m_write) begin
            finish = 1'b1;
          end else if (m_readdatavalid) begin
            // zero-latency read data arriving in the accept cycle
            finish  = 1'b1;
            capture = 1'b1;
            fin_err = rd_err;
          end
        end else if (to_hit) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_RDWAIT: begin
        if (m_readdatavalid) begin
          finish  = 1'b1;
          capture = 1'b1;
          fin_err = rd_err;
        end else if (to_hit) begin
          finish   = 1'b1;
          fin_err  = 1'b1;
          to_stale = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transfer FSM with registered Avalon command, Wishbone response and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      stale        <= 1'b0;
      abort_q      <= 1'b0;
      to_cnt       <= '0;
      wb_dat_o     <= '0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      err_count    <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (capture) begin
        wb_dat_o <= m_readdata;
      end
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          to_cnt  <= '0;
          if (stale) begin
            if (m_readdatavalid) begin
              stale <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end else if (wb_cyc_i && wb_stb_i) begin
            m_address    <= wb_adr_i;
            m_writedata  <= wb_dat_i;
            m_byteenable <= wb_sel_i;
            m_read       <= ~wb_we_i;
            m_write      <= wb_we_i;
            state        <= S_REQ;
          end
        end
        S_REQ, S_RDWAIT: begin
          if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
          if (to_cnt != TO_LIM) begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (finish) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= S_RESP;
            if (to_stale) begin
              stale <= 1'b1;
            end
            if (!quiet) begin
              wb_ack_o <= ~fin_err;
              wb_err_o <= fin_err;
              if (fin_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 1'b1;
              end
            end
          end else if ((state == S_REQ) && !m_waitrequest) begin
            // read accepted, data still outstanding
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= S_RDWAIT;
          end
        end
        S_RESP: begin
          // stb is ignored here so a held strobe cannot reissue the command
          if (stale && m_readdatavalid) begin
            stale <= 1'b0;
          end
          state <= S_IDLE;
        end
        S_DRAIN: begin
          // swallow the late beat of a timed-out read
          if (m_readdatavalid) begin
            stale <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
